// File: rtl/pc_trace_pkg.sv
// pc_trace_pkg: shared state encoding and width helpers for the PC trace monitor
// Contents:
//   pc_trace_state_e  monitor FSM states
//   ptr_w(depth)      history pointer / index width
//   cnt_w(depth)      width able to hold 0..depth valid-entry counts
package pc_trace_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED,
        TIMEOUT
    } pc_trace_state_e;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/trace_ram.sv
// trace_ram: DEPTH x WIDTH history store, one sync write port, one registered read-old-data port
// Ports:
//   clk_i    clock
//   rst_n_i  sync active-low reset, clears only the read data register
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address, sampled every edge
//   rdata_o  registered read data (old contents on same-address write)
module trace_ram
    import pc_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      we_i,
    input  logic [ptr_w(DEPTH)-1:0]   waddr_i,
    input  logic [WIDTH-1:0]          wdata_i,
    input  logic [ptr_w(DEPTH)-1:0]   raddr_i,
    output logic [WIDTH-1:0]          rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Read port samples the array before this edge's write lands
    always_ff @(posedge clk_i) begin
        rdata_q <= !rst_n_i ? '0 : mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pc_trace_monitor.sv
// pc_trace_monitor: PC history, cycle counting and halt/timeout detection for a single-cycle core
// Ports:
//   clk_i          clock
//   rst_n_i        sync active-low reset (beats clear_i and en_i)
//   clear_i        sync soft clear back to IDLE
//   en_i           capture enable (core running)
//   pc_in_i        observed PC
//   rd_idx_i       history index, 0 = most recent capture
//   rd_pc_o        registered history data for rd_idx_i
//   rd_valid_o     registered rd_idx_i < count_o
//   count_o        valid history entries, saturates at DEPTH
//   cycle_count_o  captures since reset/clear
//   running_o      state == RUN
//   halted_o       state == HALTED
//   timeout_o      state == TIMEOUT
module pc_trace_monitor
    import pc_trace_pkg::*;
#(
    parameter int PC_WIDTH    = 32,
    parameter int DEPTH       = 16,
    parameter int MAX_CYCLES  = 100,
    parameter int STALL_LIMIT = 4,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      clear_i,
    input  logic                      en_i,
    input  logic [PC_WIDTH-1:0]       pc_in_i,
    input  logic [ptr_w(DEPTH)-1:0]   rd_idx_i,
    output logic [PC_WIDTH-1:0]       rd_pc_o,
    output logic                      rd_valid_o,
    output logic [cnt_w(DEPTH)-1:0]   count_o,
    output logic [CNT_WIDTH-1:0]      cycle_count_o,
    output logic                      running_o,
    output logic                      halted_o,
    output logic                      timeout_o
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam int SW = $clog2(STALL_LIMIT) + 1;

    pc_trace_state_e     state_q, state_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [CNT_WIDTH-1:0] cyc_q, cyc_d;
    logic [SW-1:0]       stall_q, stall_d;
    logic [PC_WIDTH-1:0] last_pc_q, last_pc_d;
    logic                seen_q, seen_d;
    logic                rd_valid_q;

    logic                capture, pc_eq, halt_hit, time_hit;
    logic [CNT_WIDTH-1:0] cyc_inc;
    logic [PW-1:0]       rd_addr;

    assign capture  = state_q == RUN && en_i && !clear_i;
    // seen_q keeps the first capture after reset/clear from matching a stale last_pc
    assign pc_eq    = seen_q && pc_in_i == last_pc_q;
    assign cyc_inc  = &cyc_q ? cyc_q : cyc_q + CNT_WIDTH'(1);
    assign halt_hit = pc_eq && (int'(stall_q) + 1 == STALL_LIMIT - 1);
    assign time_hit = cyc_inc == CNT_WIDTH'(MAX_CYCLES);
    assign rd_addr  = wr_ptr_q - PW'(1) - rd_idx_i;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        cyc_d     = cyc_q;
        stall_d   = stall_q;
        last_pc_d = last_pc_q;
        seen_d    = seen_q;
        if (clear_i) begin
            state_d   = IDLE;
            wr_ptr_d  = '0;
            count_d   = '0;
            cyc_d     = '0;
            stall_d   = '0;
            last_pc_d = '0;
            seen_d    = 1'b0;
        end else if (state_q == IDLE && en_i) begin
            state_d = RUN;
        end else if (capture) begin
            wr_ptr_d  = wr_ptr_q + PW'(1);
            count_d   = count_q == CW'(DEPTH) ? count_q : count_q + CW'(1);
            cyc_d     = cyc_inc;
            stall_d   = pc_eq ? stall_q + SW'(1) : '0;
            last_pc_d = pc_in_i;
            seen_d    = 1'b1;
            // Halt outranks a timeout landing on the same capture
            state_d   = halt_hit ? HALTED : time_hit ? TIMEOUT : RUN;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            cyc_q      <= '0;
            stall_q    <= '0;
            last_pc_q  <= '0;
            seen_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            cyc_q      <= cyc_d;
            stall_q    <= stall_d;
            last_pc_q  <= last_pc_d;
            seen_q     <= seen_d;
            rd_valid_q <= CW'(rd_idx_i) < count_q;
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (PC_WIDTH)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .we_i    (capture && rst_n_i),
        .waddr_i (wr_ptr_q),
        .wdata_i (pc_in_i),
        .raddr_i (rd_addr),
        .rdata_o (rd_pc_o)
    );

    assign rd_valid_o    = rd_valid_q;
    assign count_o       = count_q;
    assign cycle_count_o = cyc_q;
    assign running_o     = state_q == RUN;
    assign halted_o      = state_q == HALTED;
    assign timeout_o     = state_q == TIMEOUT;

endmodule
